// File: rtl/rsa_modexp_if.sv
// rsa_modexp_if: request/response bundle for the modular-exponentiation engine.
//   enable   : level request, held by the master until ready, then dropped
//   base     : base operand (may be >= modulus)
//   exponent : exponent operand, scanned MSB first
//   modulus  : modulus, 0 is illegal
//   result   : base^exponent mod modulus, valid while ready=1
//   ready    : result valid, held until enable drops
//   busy     : engine working (LOAD through FINISH)
//   error    : modulus==0 seen, valid while ready=1
interface rsa_modexp_if #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 8
);
    logic                 enable;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulus;
    logic [WIDTH-1:0]     result;
    logic                 ready;
    logic                 busy;
    logic                 error;

    modport master (output enable, base, exponent, modulus,
                    input  result, ready, busy, error);
    modport slave  (input  enable, base, exponent, modulus,
                    output result, ready, busy, error);
endinterface

// File: rtl/rsa_modexp.sv
// rsa_modexp: bit-serial modular exponentiation, result = base^exponent mod modulus.
// Left-to-right square-and-multiply; every modular product is an interleaved
// shift/add/subtract multiply taking WIDTH cycles, base pre-reduced in WIDTH cycles.
// Ports:
//   i_clock : rising-edge clock
//   i_reset : asynchronous active-low reset
//   bus     : rsa_modexp_if.slave (enable/operands in, result/ready/busy/error out)
// Optional macro RSA_MODEXP_CONST_TIME_EN: run MUL for every exponent bit (product
// kept only for 1 bits) and pad the error path, giving operand-independent latency.
module rsa_modexp #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    rsa_modexp_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, REDUCE, SQR, MUL, FINISH, DONE} state_t;

    state_t               r_state;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_mod;
    logic [WIDTH-1:0]     r_b;     // base mod m
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_p;     // running partial remainder / product, always < m
    logic [WIDTH-1:0]     r_x;     // multiplier (or raw base during REDUCE), shifted MSB out
    logic [WIDTH-1:0]     r_y;     // multiplicand
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [WIDTH-1:0]     r_result;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_error;

    logic [WIDTH+1:0]     w_m, w_dbl, w_s1, w_sum, w_s2;
    logic [WIDTH-1:0]     w_prod, w_adv;
    logic                 w_go_mul;

    // One step shared by REDUCE (shift in a base bit, no add) and SQR/MUL
    // (double, then conditionally add y); each partial result is folded back below m.
    always_comb begin
        w_m    = {2'b00, r_mod};
        w_dbl  = {1'b0, r_p, (r_state == REDUCE) ? r_x[WIDTH-1] : 1'b0};
        w_s1   = (w_dbl >= w_m) ? w_dbl - w_m : w_dbl;
        w_sum  = (r_state != REDUCE && r_x[WIDTH-1]) ? w_s1 + {2'b00, r_y} : w_s1;
        w_s2   = (w_sum >= w_m) ? w_sum - w_m : w_sum;
        w_prod = WIDTH'(w_s2);
`ifdef RSA_MODEXP_CONST_TIME_EN
        w_go_mul = 1'b1;
`else
        w_go_mul = r_exp[r_idx];
`endif
        // A MUL for a zero exponent bit (constant-time only) is discarded.
        w_adv = (r_state == MUL && !r_exp[r_idx]) ? r_acc : w_prod;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= IDLE;
            r_exp    <= '0;
            r_mod    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_p      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    // r_x holds the registered base while it is reduced.
                    r_x     <= bus.base;
                    r_exp   <= bus.exponent;
                    r_mod   <= bus.modulus;
                    r_acc   <= WIDTH'(1);
                    r_p     <= '0;
                    r_cnt   <= '0;
                    r_idx   <= IW'(EXP_WIDTH - 1);
                    r_error <= (bus.modulus == '0);
`ifdef RSA_MODEXP_CONST_TIME_EN
                    r_state <= REDUCE;
`else
                    r_state <= (bus.modulus == '0) ? FINISH : REDUCE;
`endif
                end
                REDUCE: begin
                    r_p   <= w_prod;
                    r_x   <= r_x << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_b     <= w_prod;
                        r_p     <= '0;
                        r_x     <= r_acc;
                        r_y     <= r_acc;
                        r_cnt   <= '0;
                        r_state <= SQR;
                    end
                end
                SQR, MUL: begin
                    r_p   <= w_prod;
                    r_x   <= r_x << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_acc <= w_adv;
                        r_p   <= '0;
                        r_cnt <= '0;
                        if (r_state == SQR && w_go_mul) begin
                            r_x     <= w_adv;
                            r_y     <= r_b;
                            r_state <= MUL;
                        end else if (r_idx == '0) begin
                            r_state <= FINISH;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            r_x     <= w_adv;
                            r_y     <= w_adv;
                            r_state <= SQR;
                        end
                    end
                end
                FINISH: begin
                    r_result <= r_error ? '0 : r_acc;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (!bus.enable) begin
                        r_ready  <= 1'b0;
                        r_error  <= 1'b0;
                        r_result <= '0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.ready  = r_ready;
    assign bus.busy   = r_busy;
    assign bus.error  = r_error;
endmodule

// File: tb/tb_rsa_modexp.sv
module tb_rsa_modexp;
`ifdef RSA_MODEXP_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif
    localparam int LIMIT = 5000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    rsa_modexp_if #(.WIDTH(8),  .EXP_WIDTH(8))  bus8();
    rsa_modexp_if #(.WIDTH(32), .EXP_WIDTH(17)) bus32();

    rsa_modexp #(.WIDTH(8),  .EXP_WIDTH(8))  u8  (.i_clock(clk), .i_reset(rst_n), .bus(bus8.slave));
    rsa_modexp #(.WIDTH(32), .EXP_WIDTH(17)) u32 (.i_clock(clk), .i_reset(rst_n), .bus(bus32.slave));

    // Reference: right-to-left binary exponentiation on 64-bit integers.
    function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] e,
                                               input logic [63:0] m);
        logic [63:0] r;
        r = 1;
        b = b % m;
        while (e != 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return r % m;
    endfunction

    function automatic int ref_lat(input int w, input int ew, input int pop, input bit err);
        if (CT) return 2 + w * (1 + 2 * ew);
        if (err) return 2;
        return 2 + w * (1 + ew + pop);
    endfunction

    // Drives one 8-bit transaction; returns result, error, latency, and state after drop.
    task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                        input int drop_at, output logic [7:0] res, output logic err,
                        output int lat, output bit ok, output logic busy_done,
                        output logic rdy_after);
        @(negedge clk);
        bus8.base = b; bus8.exponent = e; bus8.modulus = m; bus8.enable = 1'b1;
        @(posedge clk);
        lat = 0; ok = 1'b1;
        forever begin
            @(negedge clk);
            if (bus8.ready) break;
            if (lat == drop_at) bus8.enable = 1'b0;
            if (lat > LIMIT) begin ok = 1'b0; break; end
            @(posedge clk);
            lat++;
        end
        res = bus8.result; err = bus8.error; busy_done = bus8.busy;
        bus8.enable = 1'b0;
        @(negedge clk);
        rdy_after = bus8.ready;
    endtask

    task automatic run32(input logic [31:0] b, input logic [16:0] e, input logic [31:0] m,
                         input int scramble_at, output logic [31:0] res, output logic err,
                         output int lat, output bit ok);
        @(negedge clk);
        bus32.base = b; bus32.exponent = e; bus32.modulus = m; bus32.enable = 1'b1;
        @(posedge clk);
        lat = 0; ok = 1'b1;
        forever begin
            @(negedge clk);
            if (bus32.ready) break;
            if (lat == scramble_at) begin
                bus32.base = $urandom; bus32.exponent = 17'($urandom); bus32.modulus = $urandom;
            end
            if (lat > LIMIT) begin ok = 1'b0; break; end
            @(posedge clk);
            lat++;
        end
        res = bus32.result; err = bus32.error;
        bus32.enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus8.enable = 0; bus8.base = 0; bus8.exponent = 0; bus8.modulus = 0;
        bus32.enable = 0; bus32.base = 0; bus32.exponent = 0; bus32.modulus = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus8.result, bus8.ready, bus8.busy, bus8.error} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset8: got res=%0d rdy=%0b busy=%0b err=%0b, want all 0",
                     bus8.result, bus8.ready, bus8.busy, bus8.error);
        end
        n_cmp++;
        if ({bus32.result, bus32.ready, bus32.busy, bus32.error} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset32: got res=%0h rdy=%0b busy=%0b err=%0b, want all 0",
                     bus32.result, bus32.ready, bus32.busy, bus32.error);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] res; logic err, bd, ra; int lat; bit ok;
        int want_lat;
        want_lat = CT ? 138 : 90;
        run8(8'd7, 8'd3, 8'd99, -1, res, err, lat, ok, bd, ra);
        n_cmp++;
        if (!ok || res !== 8'd46 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_7^3%%99: got res=%0d err=%0b ok=%0b, want 46/0", res, err, ok);
        end
        n_cmp++;
        if (lat != want_lat) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, want %0d", lat, want_lat);
        end
        n_cmp++;
        if (bd !== 1'b0 || ra !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_handshake: busy_at_done=%0b ready_after_drop=%0b, want 0/0", bd, ra);
        end
    endtask

    task automatic test_boundaries;
        logic [7:0] tb_b[6]; logic [7:0] tb_e[6]; logic [7:0] tb_m[6]; logic [7:0] tb_r[6];
        logic [7:0] res; logic err, bd, ra; int lat; bit ok;
        tb_b = '{8'd5, 8'd200, 8'd123, 8'd77, 8'd0,  8'd255};
        tb_e = '{8'd5, 8'd2,   8'd0,   8'd201, 8'd0, 8'd255};
        tb_m = '{8'd5, 8'd7,   8'd99,  8'd1,  8'd13, 8'd255};
        tb_r = '{8'd0, 8'd2,   8'd1,   8'd0,  8'd1,  8'd0};
        for (int i = 0; i < 6; i++) begin
            run8(tb_b[i], tb_e[i], tb_m[i], -1, res, err, lat, ok, bd, ra);
            n_cmp++;
            if (!ok || res !== tb_r[i] || err !== 1'b0 ||
                lat != ref_lat(8, 8, $countones(tb_e[i]), 1'b0)) begin
                n_fail++;
                $display("FAIL boundary_%0d (%0d^%0d mod %0d): got res=%0d err=%0b lat=%0d, want %0d/0/%0d",
                         i, tb_b[i], tb_e[i], tb_m[i], res, err, lat, tb_r[i],
                         ref_lat(8, 8, $countones(tb_e[i]), 1'b0));
            end
        end
    endtask

    task automatic test_error;
        logic [7:0] res; logic err, bd, ra; int lat; bit ok;
        run8(8'd9, 8'd3, 8'd0, -1, res, err, lat, ok, bd, ra);
        n_cmp++;
        if (!ok || err !== 1'b1 || res !== 8'd0 || lat != ref_lat(8, 8, 2, 1'b1)) begin
            n_fail++;
            $display("FAIL error_mod0: got err=%0b res=%0d lat=%0d, want 1/0/%0d",
                     err, res, lat, ref_lat(8, 8, 2, 1'b1));
        end
        n_cmp++;
        if (ra !== 1'b0 || bus8.error !== 1'b0) begin
            n_fail++;
            $display("FAIL error_clear: ready=%0b error=%0b after drop, want 0/0", ra, bus8.error);
        end
    endtask

    task automatic test_random8;
        logic [7:0] b, e, m, res; logic err, bd, ra; int lat; bit ok;
        logic [7:0] want;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom); e = 8'($urandom); m = 8'($urandom_range(255, 1));
            want = 8'(ref_modexp({56'd0, b}, {56'd0, e}, {56'd0, m}));
            run8(b, e, m, -1, res, err, lat, ok, bd, ra);
            n_cmp++;
            if (!ok || res !== want || err !== 1'b0 || lat != ref_lat(8, 8, $countones(e), 1'b0)) begin
                n_fail++;
                $display("FAIL random8_%0d (%0d^%0d mod %0d): got res=%0d err=%0b lat=%0d, want %0d/0/%0d",
                         i, b, e, m, res, err, lat, want, ref_lat(8, 8, $countones(e), 1'b0));
            end
        end
    endtask

    task automatic test_early_drop;
        logic [7:0] res; logic err, bd, ra; int lat; bit ok;
        run8(8'd7, 8'd3, 8'd99, 3, res, err, lat, ok, bd, ra);
        n_cmp++;
        if (!ok || res !== 8'd46 || lat != ref_lat(8, 8, 2, 1'b0) || ra !== 1'b0) begin
            n_fail++;
            $display("FAIL early_drop: got res=%0d lat=%0d ready_next=%0b, want 46/%0d/0",
                     res, lat, ra, ref_lat(8, 8, 2, 1'b0));
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] res; logic err, bd, ra; int lat; bit ok;
        @(negedge clk);
        bus8.base = 8'd7; bus8.exponent = 8'd3; bus8.modulus = 8'd99; bus8.enable = 1'b1;
        @(posedge clk);
        repeat (40) @(posedge clk);
        #2;
        n_cmp++;
        if (bus8.busy !== 1'b1 || bus8.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_status: busy=%0b ready=%0b, want 1/0", bus8.busy, bus8.ready);
        end
        rst_n = 0;
        #1;
        n_cmp++;
        if ({bus8.result, bus8.ready, bus8.busy, bus8.error} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: got res=%0d rdy=%0b busy=%0b err=%0b, want all 0",
                     bus8.result, bus8.ready, bus8.busy, bus8.error);
        end
        bus8.enable = 1'b0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run8(8'd7, 8'd3, 8'd99, -1, res, err, lat, ok, bd, ra);
        n_cmp++;
        if (!ok || res !== 8'd46 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rerun_after_reset: got res=%0d err=%0b, want 46/0", res, err);
        end
    endtask

    task automatic test_wide;
        logic [31:0] b, m, res, want; logic [16:0] e; logic err; int lat; bit ok;
        b = 32'h0123_4567; e = 17'd65537; m = 32'hFFFF_FFFB;
        want = 32'(ref_modexp({32'd0, b}, {47'd0, e}, {32'd0, m}));
        run32(b, e, m, 100, res, err, lat, ok);
        n_cmp++;
        if (!ok || res !== want || err !== 1'b0 || lat != ref_lat(32, 17, 2, 1'b0)) begin
            n_fail++;
            $display("FAIL wide_65537: got res=%0h err=%0b lat=%0d, want %0h/0/%0d",
                     res, err, lat, want, ref_lat(32, 17, 2, 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            b = $urandom; e = 17'($urandom); m = $urandom | 32'h1;
            want = 32'(ref_modexp({32'd0, b}, {47'd0, e}, {32'd0, m}));
            run32(b, e, m, -1, res, err, lat, ok);
            n_cmp++;
            if (!ok || res !== want || lat != ref_lat(32, 17, $countones(e), 1'b0)) begin
                n_fail++;
                $display("FAIL wide_random_%0d: got res=%0h lat=%0d, want %0h/%0d",
                         i, res, lat, want, ref_lat(32, 17, $countones(e), 1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_error();
        test_random8();
        test_early_drop();
        test_async_reset();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
